// File: rtl/plot_sink_pkg.sv
// Shared frame geometry, colour and state encodings for the plot sink.
// Imported by plot_sink and its address helper.
package plot_sink_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int ADDR_W_DEF   = 15;

  typedef logic [2:0] colour_t;

  localparam colour_t COL_BLACK = 3'b000;
  localparam colour_t COL_WHITE = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/plot_sink_pixel_addr.sv
// Linear frame-buffer address y*SCREEN_W+x and on-screen test.
// Purely combinational; all state lives in plot_sink.
module pixel_addr
  import plot_sink_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  // Widen before multiplying so the product never truncates.
  assign addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);

  assign in_range = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);

endmodule

// File: rtl/plot_sink.sv
// Frame-buffer write port: single pixel plots plus a full-frame clear,
// with a saturating count of plots that never reached memory.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        colour,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  output logic              ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic [7:0]        dropped
);

  localparam logic [ADDR_W-1:0] FILL_LAST =
    ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  colour_t           clr_col_q, clr_col_d;
  logic              pwr_q, pwr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  colour_t           pdata_q, pdata_d;
  logic [7:0]        drop_q, drop_d;
  logic              drop_ev;

  logic [ADDR_W-1:0] pix_addr;
  logic              pix_ok;

  pixel_addr #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_pixel_addr (
    .x        (x),
    .y        (y),
    .addr     (pix_addr),
    .in_range (pix_ok)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      fill_q    <= '0;
      clr_col_q <= COL_BLACK;
      pwr_q     <= 1'b0;
      paddr_q   <= '0;
      pdata_q   <= COL_BLACK;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      clr_col_q <= clr_col_d;
      pwr_q     <= pwr_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    clr_col_d = clr_col_q;
    pwr_d     = 1'b0;
    paddr_d   = paddr_q;
    pdata_d   = pdata_q;
    drop_ev   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A clear wins over a simultaneous plot.
        if (clear) begin
          state_d   = S_CLEAR;
          fill_d    = '0;
          clr_col_d = clear_colour;
          drop_ev   = plot;
        end else if (plot) begin
          if (pix_ok) begin
            pwr_d   = 1'b1;
            paddr_d = pix_addr;
            pdata_d = colour;
          end else begin
            drop_ev = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        drop_ev = plot;
        if (fill_q == FILL_LAST) begin
          state_d = S_IDLE;
        end else begin
          fill_d = fill_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    drop_d = (drop_ev && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_comb begin
    ready   = (state_q == S_IDLE);
    wr_en   = pwr_q;
    wr_addr = paddr_q;
    wr_data = pdata_q;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = fill_q;
      wr_data = clr_col_q;
    end
  end

  assign dropped = drop_q;

endmodule

// File: tb/tb_plot_sink.sv
// Directed checks of plot_sink: plots, range drops, full clear,
// clear/plot collision, saturation and reset during a fill.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        clear;
  logic [2:0]  clear_colour;
  logic        ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic [7:0]  dropped;

  int compared = 0;
  int mismatched = 0;

  plot_sink dut (
    .clk          (clk),
    .resetn       (resetn),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear        (clear),
    .clear_colour (clear_colour),
    .ready        (ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    plot = 1'b0;
    clear = 1'b0;
    x = 8'd0;
    y = 7'd0;
    colour = 3'd0;
    clear_colour = 3'd0;
  endtask

  initial begin
    int bad;
    int first_bad;
    idle_in();
    resetn = 1'b0;
    plot = 1'b1;
    clear = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_dropped", 32'(dropped), 0);
    idle_in();
    resetn = 1'b1;
    tick();

    // single plot, latency 1
    plot = 1'b1; x = 8'd5; y = 7'd2; colour = 3'b101;
    tick();
    plot = 1'b0;
    check("p1_wr_en", 32'(wr_en), 1);
    check("p1_addr", 32'(wr_addr), 325);
    check("p1_data", 32'(wr_data), 5);
    check("p1_dropped", 32'(dropped), 0);
    tick();
    check("p1_after_wr_en", 32'(wr_en), 0);

    // back-to-back corner plots
    plot = 1'b1; x = 8'd0; y = 7'd0; colour = 3'b011;
    tick();
    x = 8'd159; y = 7'd119; colour = 3'b110;
    check("b2b0_wr_en", 32'(wr_en), 1);
    check("b2b0_addr", 32'(wr_addr), 0);
    check("b2b0_data", 32'(wr_data), 3);
    tick();
    plot = 1'b0;
    check("b2b1_wr_en", 32'(wr_en), 1);
    check("b2b1_addr", 32'(wr_addr), 19199);
    check("b2b1_data", 32'(wr_data), 6);
    tick();
    check("b2b_end_wr_en", 32'(wr_en), 0);

    // out-of-range plots
    plot = 1'b1; x = 8'd160; y = 7'd0;
    tick();
    check("oor_x_wr_en", 32'(wr_en), 0);
    x = 8'd0; y = 7'd120;
    tick();
    plot = 1'b0;
    check("oor_y_wr_en", 32'(wr_en), 0);
    check("oor_dropped", 32'(dropped), 2);

    // full clear; a plot and a clear arrive mid-fill
    clear = 1'b1; clear_colour = 3'b000;
    tick();
    clear = 1'b0;
    check("clr_ready", 32'(ready), 0);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      if (!(wr_en === 1'b1 && wr_addr === 15'(i) &&
            wr_data === 3'b000 && ready === 1'b0)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      plot = (i == 50);
      x = 8'd1; y = 7'd1; colour = 3'b111;
      clear = (i == 60);
      clear_colour = 3'b111;
      tick();
    end
    idle_in();
    check("clr_seq_bad_cycles", 32'(bad), 0);
    check("clr_seq_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
    check("clr_done_ready", 32'(ready), 1);
    check("clr_done_wr_en", 32'(wr_en), 0);
    check("clr_dropped", 32'(dropped), 3);

    // clear and plot in the same idle cycle
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    clear = 1'b1; clear_colour = 3'b110;
    plot = 1'b1; x = 8'd3; y = 7'd3; colour = 3'b001;
    tick();
    idle_in();
    check("cp_ready", 32'(ready), 0);
    check("cp_wr_en", 32'(wr_en), 1);
    check("cp_addr", 32'(wr_addr), 0);
    check("cp_data", 32'(wr_data), 6);
    check("cp_dropped", 32'(dropped), 1);
    repeat (100) tick();
    check("mid_addr", 32'(wr_addr), 100);
    resetn = 1'b0;
    tick();
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_ready", 32'(ready), 1);
    check("mid_rst_dropped", 32'(dropped), 0);
    resetn = 1'b1;
    tick();
    check("post_rst_wr_en", 32'(wr_en), 0);

    // saturation
    plot = 1'b1; x = 8'd200; y = 7'd5;
    repeat (254) tick();
    check("sat_254", 32'(dropped), 254);
    repeat (46) tick();
    plot = 1'b0;
    check("sat_255", 32'(dropped), 255);
    check("sat_wr_en", 32'(wr_en), 0);

    // reset during clear at fill address 100
    clear = 1'b1; clear_colour = 3'b010;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    check("sat_mid_addr", 32'(wr_addr), 100);
    check("sat_mid_data", 32'(wr_data), 2);
    resetn = 1'b0;
    tick();
    check("sat_rst_wr_en", 32'(wr_en), 0);
    check("sat_rst_ready", 32'(ready), 1);
    check("sat_rst_dropped", 32'(dropped), 0);
    resetn = 1'b1;
    repeat (3) tick();
    check("sat_post_wr_en", 32'(wr_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
